// File: rtl/conv_bram_1d_pingpong_sched.sv
// Ping-pong image-bank scheduler for the 1D BRAM convolution engine: the loader
// fills one bank while the engine convolves the other, then the banks swap.
module conv_bram_1d_pingpong_sched #(
    parameter  int DATA_WIDTH         = 8,
    parameter  int IMG_W              = 32,
    parameter  int IMG_D              = 4,
    parameter  int FILTER_L           = 3,
    parameter  int STRIDE_W           = 1,
    parameter  int JOB_CNT_WIDTH      = 16,
    localparam int RESULT_W           = (IMG_W - FILTER_L) / STRIDE_W + 1,
    localparam int IMG_RAM_ADDR_WIDTH = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_val,
    output logic                          ld_rdy,
    input  logic [DATA_WIDTH*IMG_D-1:0]   ld_data,
    output logic [IMG_RAM_ADDR_WIDTH-1:0] bank_wraddr,
    output logic [DATA_WIDTH*IMG_D-1:0]   bank_wrdata,
    output logic [1:0]                    bank_wren,
    output logic                          rd_bank_sel,
    output logic                          eng_val,
    input  logic                          eng_rdy,
    input  logic                          eng_result_wren,
    output logic [1:0]                    bank_full,
    output logic [JOB_CNT_WIDTH-1:0]      jobs_done,
    output logic                          err
);

    localparam int RES_CNT_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam logic [IMG_RAM_ADDR_WIDTH-1:0] WR_LAST  = IMG_RAM_ADDR_WIDTH'(IMG_W - 1);
    localparam logic [RES_CNT_WIDTH-1:0]      RES_LAST = RES_CNT_WIDTH'(RESULT_W - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_BUSY
    } bank_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_ISSUE,
        ENG_RUN
    } eng_state_t;

    bank_state_t                   bank_state [2];
    eng_state_t                    eng_state;
    logic                          fill_ptr;
    logic                          run_ptr;
    logic [IMG_RAM_ADDR_WIDTH-1:0] wr_cnt;
    logic [RES_CNT_WIDTH-1:0]      res_cnt;
    logic                          ld_accept;

    assign ld_rdy      = (bank_state[fill_ptr] == BANK_EMPTY) ||
                         (bank_state[fill_ptr] == BANK_FILLING);
    assign ld_accept   = ld_val && ld_rdy;
    assign bank_wraddr = wr_cnt;
    assign bank_wrdata = ld_data;

    // Write enable is combinational so a column lands in the bank the same
    // cycle it is accepted.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bank_wren = '0;
        if (ld_accept) begin
            bank_wren[fill_ptr] = 1'b1;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_full[b] = (bank_state[b] == BANK_FULL) || (bank_state[b] == BANK_BUSY);
        end
    end

    // Loader and engine only ever touch a bank in disjoint states (EMPTY/FILLING
    // versus FULL/BUSY), so their same-cycle updates never collide.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_EMPTY;
            end
            eng_state   <= ENG_IDLE;
            fill_ptr    <= 1'b0;
            run_ptr     <= 1'b0;
            wr_cnt      <= '0;
            res_cnt     <= '0;
            eng_val     <= 1'b0;
            rd_bank_sel <= 1'b0;
            jobs_done   <= '0;
            err         <= 1'b0;
        end else begin
            if (ld_accept) begin
                if (wr_cnt == WR_LAST) begin
                    bank_state[fill_ptr] <= BANK_FULL;
                    wr_cnt               <= '0;
                    fill_ptr             <= ~fill_ptr;
                end else begin
                    bank_state[fill_ptr] <= BANK_FILLING;
                    wr_cnt               <= wr_cnt + IMG_RAM_ADDR_WIDTH'(1);
                end
            end

            case (eng_state)
                ENG_IDLE: begin
                    if (bank_state[run_ptr] == BANK_FULL) begin
                        eng_state   <= ENG_ISSUE;
                        eng_val     <= 1'b1;
                        rd_bank_sel <= run_ptr;
                    end
                end
                ENG_ISSUE: begin
                    if (eng_rdy) begin
                        bank_state[run_ptr] <= BANK_BUSY;
                        res_cnt             <= '0;
                        eng_val             <= 1'b0;
                        eng_state           <= ENG_RUN;
                    end
                end
                ENG_RUN: begin
                    if (eng_result_wren) begin
                        if (res_cnt == RES_LAST) begin
                            bank_state[run_ptr] <= BANK_EMPTY;
                            run_ptr             <= ~run_ptr;
                            jobs_done           <= jobs_done + JOB_CNT_WIDTH'(1);
                            eng_state           <= ENG_IDLE;
                        end else begin
                            res_cnt <= res_cnt + RES_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    eng_state <= ENG_IDLE;
                    eng_val   <= 1'b0;
                end
            endcase

            // A result write outside RUN has no job to belong to.
            if (eng_result_wren && (eng_state != ENG_RUN)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
